// File: rtl/riscv_run_monitor_pkg.sv
// Shared types and constants for the RISC-V run/halt monitor.
package riscv_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mon_state_t;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        ECALL    = 3'd1,
        EBREAK   = 3'd2,
        SELFLOOP = 3'd3,
        TIMEOUT  = 3'd4
    } mon_cause_t;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/riscv_run_monitor_if.sv
// Retire-stream and status bundle between the core side (master) and the monitor (slave).
interface riscv_run_monitor_if
    import riscv_mon_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             start;
    logic             instr_valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic             busy;
    logic             finish_flag;
    logic             timeout_flag;
    mon_cause_t       cause;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instret_count;

    modport master (
        output start, instr_valid, pc, instr,
        input  busy, finish_flag, timeout_flag, cause, cycle_count, instret_count
    );

    modport slave (
        input  start, instr_valid, pc, instr,
        output busy, finish_flag, timeout_flag, cause, cycle_count, instret_count
    );
endinterface

// File: rtl/riscv_run_monitor_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/riscv_run_monitor.sv
// Run/halt monitor: watches the retire stream, detects halts/timeouts and latches the cause.
//   state | meaning
//   IDLE  | waiting for the first start after reset
//   RUN   | program running, halt/loop/watchdog detection active
//   DRAIN | halt seen, letting the pipeline settle for DRAIN_CYCLES
//   DONE  | finished, outputs frozen until the next start
module riscv_run_monitor
    import riscv_mon_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int LOOP_REPEAT    = 2,
    parameter int DRAIN_CYCLES   = 1
) (
    input  logic          clock,
    input  logic          rst_n,
    riscv_run_monitor_if.slave mon
);
    localparam logic [63:0] TO_LAST    = 64'(TIMEOUT_CYCLES) - 64'd1;
    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
    localparam logic [31:0] LOOP_N     = 32'(LOOP_REPEAT);

    mon_state_t      r_state;
    mon_cause_t      r_cause;
    logic            r_busy;
    logic            r_finish;
    logic            r_timeout;
    logic [31:0]     r_drain_cnt;
    logic [XLEN-1:0] r_last_pc;
    logic            r_last_pc_valid;
    logic [31:0]     r_loop_cnt;

    logic [CNT_W-1:0] w_cycle_count;
    logic [CNT_W-1:0] w_instret_count;
    logic             w_start_acc;
    logic             w_retire;
    logic             w_cyc_en;
    logic             w_is_ecall;
    logic             w_is_ebreak;
    logic             w_pc_match;
    logic             w_loop_hit;
    logic             w_timeout;
    logic             w_halt;
    mon_cause_t       w_halt_cause;

    assign w_start_acc = mon.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_retire    = mon.instr_valid && (r_state == RUN);
    assign w_cyc_en    = (r_state == RUN) || (r_state == DRAIN);
    assign w_is_ecall  = w_retire && (mon.instr[31:0] == INSTR_ECALL);
    assign w_is_ebreak = w_retire && (mon.instr[31:0] == INSTR_EBREAK);
    assign w_pc_match  = r_last_pc_valid && (mon.pc == r_last_pc);
    // r_loop_cnt is the pre-update count, so this retire is repeat number r_loop_cnt+2.
    assign w_loop_hit  = (LOOP_REPEAT != 0) && w_retire && w_pc_match &&
                         ((r_loop_cnt + 32'd2) == LOOP_N);
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_state == RUN) &&
                         (64'(w_cycle_count) == TO_LAST);
    assign w_halt      = w_is_ecall || w_is_ebreak || w_loop_hit;

    always_comb begin
        w_halt_cause = NONE;
        if (w_is_ecall)       w_halt_cause = ECALL;
        else if (w_is_ebreak) w_halt_cause = EBREAK;
        else if (w_loop_hit)  w_halt_cause = SELFLOOP;
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock   (clock),
        .rst_n   (rst_n),
        .i_clr   (w_start_acc),
        .i_en    (w_cyc_en),
        .o_count (w_cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_instret_cnt (
        .clock   (clock),
        .rst_n   (rst_n),
        .i_clr   (w_start_acc),
        .i_en    (w_retire),
        .o_count (w_instret_count)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cause     <= NONE;
            r_busy      <= 1'b0;
            r_finish    <= 1'b0;
            r_timeout   <= 1'b0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_acc) begin
                        r_state     <= RUN;
                        r_cause     <= NONE;
                        r_busy      <= 1'b1;
                        r_finish    <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_drain_cnt <= '0;
                    end
                end
                RUN: begin
                    if (w_halt) begin
                        r_cause     <= w_halt_cause;
                        r_drain_cnt <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            r_state  <= DONE;
                            r_busy   <= 1'b0;
                            r_finish <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end else if (w_timeout) begin
                        r_state   <= DONE;
                        r_cause   <= TIMEOUT;
                        r_busy    <= 1'b0;
                        r_finish  <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_finish <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_last_pc       <= '0;
            r_last_pc_valid <= 1'b0;
            r_loop_cnt      <= '0;
        end else if (w_start_acc) begin
            r_last_pc_valid <= 1'b0;
            r_loop_cnt      <= '0;
        end else if (w_retire) begin
            if (!r_last_pc_valid || !w_pc_match) begin
                r_last_pc       <= mon.pc;
                r_last_pc_valid <= 1'b1;
                r_loop_cnt      <= '0;
            end else if (r_loop_cnt != '1) begin
                r_loop_cnt <= r_loop_cnt + 32'd1;
            end
        end
    end

    assign mon.busy          = r_busy;
    assign mon.finish_flag   = r_finish;
    assign mon.timeout_flag  = r_timeout;
    assign mon.cause         = r_cause;
    assign mon.cycle_count   = w_cycle_count;
    assign mon.instret_count = w_instret_count;
endmodule

// File: tb/tb_riscv_run_monitor.sv
// Scenario bench for riscv_run_monitor: two configurations, expected finish records queued per run.
module tb_riscv_run_monitor;
    import riscv_mon_pkg::*;

    localparam logic [31:0] ADD = 32'h00b5_0533;
    localparam logic [31:0] JAL = 32'h0000_006f;

    typedef struct packed {
        logic [2:0]  cause;
        logic        to;
        logic [31:0] cyc;
        logic [31:0] ret;
    } res_t;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    riscv_run_monitor_if #(.XLEN(32), .CNT_W(32)) ifa ();
    riscv_run_monitor_if #(.XLEN(32), .CNT_W(4))  ifb ();

    riscv_run_monitor #(.XLEN(32), .CNT_W(32), .TIMEOUT_CYCLES(20),
                        .LOOP_REPEAT(2), .DRAIN_CYCLES(1)) u_dut_a (
        .clock (clock), .rst_n (rst_n), .mon (ifa));

    riscv_run_monitor #(.XLEN(32), .CNT_W(4), .TIMEOUT_CYCLES(0),
                        .LOOP_REPEAT(3), .DRAIN_CYCLES(0)) u_dut_b (
        .clock (clock), .rst_n (rst_n), .mon (ifb));

    int   ntot = 0;
    int   nbad = 0;
    int   n;
    res_t exp_q[$];
    res_t expv;
    res_t obs;

    // One call = one rising edge; returns at the following falling edge.
    task automatic step_a(input logic s, input logic v, input logic [31:0] p, input logic [31:0] i);
        ifa.start = s; ifa.instr_valid = v; ifa.pc = p; ifa.instr = i;
        @(negedge clock);
    endtask

    task automatic step_b(input logic s, input logic v, input logic [31:0] p, input logic [31:0] i);
        ifb.start = s; ifb.instr_valid = v; ifb.pc = p; ifb.instr = i;
        @(negedge clock);
    endtask

    task automatic test_reset();
        #12;
        ntot++;
        if ({ifa.busy, ifa.finish_flag, ifa.timeout_flag, ifa.cause, ifa.cycle_count, ifa.instret_count} !== '0) begin
            nbad++;
            $display("FAIL reset_a: busy=%b fin=%b to=%b cause=%0d cyc=%0d ret=%0d, want all 0",
                     ifa.busy, ifa.finish_flag, ifa.timeout_flag, ifa.cause, ifa.cycle_count, ifa.instret_count);
        end
        ntot++;
        if ({ifb.busy, ifb.finish_flag, ifb.timeout_flag, ifb.cause, ifb.cycle_count, ifb.instret_count} !== '0) begin
            nbad++;
            $display("FAIL reset_b: busy=%b fin=%b to=%b cause=%0d cyc=%0d ret=%0d, want all 0",
                     ifb.busy, ifb.finish_flag, ifb.timeout_flag, ifb.cause, ifb.cycle_count, ifb.instret_count);
        end
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_ecall();
        step_a(1'b1, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 5; k++) step_a(1'b0, 1'b1, 32'h4 + 32'(4 * k), ADD);
        step_a(1'b0, 1'b1, 32'h18, INSTR_ECALL);
        exp_q.push_back({ECALL, 1'b0, 32'd7, 32'd6});
        ntot++;
        if (ifa.finish_flag !== 1'b0 || ifa.busy !== 1'b1) begin
            nbad++;
            $display("FAIL ecall_drain: fin=%b busy=%b, want fin=0 busy=1", ifa.finish_flag, ifa.busy);
        end
        n = 0;
        while (ifa.finish_flag !== 1'b1 && n < 64) begin step_a(1'b0, 1'b0, 32'h0, 32'h0); n++; end
        ntot++;
        if (n !== 1 || ifa.busy !== 1'b0) begin
            nbad++;
            $display("FAIL ecall_latency: edges=%0d busy=%b, want edges=1 busy=0", n, ifa.busy);
        end
        expv = exp_q.pop_front();
        obs  = {ifa.cause, ifa.timeout_flag, ifa.cycle_count, ifa.instret_count};
        ntot++;
        if (obs !== expv) begin
            nbad++;
            $display("FAIL ecall_result: got %h want %h", obs, expv);
        end
        // Retires and extra cycles in DONE must not disturb anything.
        for (int k = 0; k < 3; k++) step_a(1'b0, 1'b1, 32'h18, INSTR_EBREAK);
        obs = {ifa.cause, ifa.timeout_flag, ifa.cycle_count, ifa.instret_count};
        ntot++;
        if (obs !== expv || ifa.finish_flag !== 1'b1) begin
            nbad++;
            $display("FAIL done_hold: got %h fin=%b want %h fin=1", obs, ifa.finish_flag, expv);
        end
    endtask

    task automatic test_selfloop();
        step_a(1'b1, 1'b0, 32'h0, 32'h0);
        step_a(1'b0, 1'b1, 32'h3c, ADD);
        step_a(1'b0, 1'b1, 32'h40, JAL);
        ntot++;
        if (ifa.busy !== 1'b1 || ifa.finish_flag !== 1'b0 || ifa.cause !== NONE) begin
            nbad++;
            $display("FAIL loop_first: busy=%b fin=%b cause=%0d, want 1 0 0", ifa.busy, ifa.finish_flag, ifa.cause);
        end
        step_a(1'b0, 1'b1, 32'h40, JAL);
        exp_q.push_back({SELFLOOP, 1'b0, 32'd4, 32'd3});
        n = 0;
        while (ifa.finish_flag !== 1'b1 && n < 64) begin step_a(1'b0, 1'b0, 32'h0, 32'h0); n++; end
        ntot++;
        if (n !== 1) begin
            nbad++;
            $display("FAIL loop_latency: edges=%0d want 1", n);
        end
        expv = exp_q.pop_front();
        obs  = {ifa.cause, ifa.timeout_flag, ifa.cycle_count, ifa.instret_count};
        ntot++;
        if (obs !== expv) begin
            nbad++;
            $display("FAIL loop_result: got %h want %h", obs, expv);
        end
    endtask

    task automatic test_timeout();
        step_a(1'b1, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 10; k++) step_a(1'b0, 1'b1, 32'h100 + 32'(4 * k), ADD);
        for (int k = 0; k < 9; k++)  step_a(1'b0, 1'b0, 32'h0, 32'h0);
        ntot++;
        if (ifa.cycle_count !== 32'd19 || ifa.finish_flag !== 1'b0) begin
            nbad++;
            $display("FAIL pre_timeout: cyc=%0d fin=%b, want cyc=19 fin=0", ifa.cycle_count, ifa.finish_flag);
        end
        exp_q.push_back({TIMEOUT, 1'b1, 32'd20, 32'd10});
        n = 0;
        while (ifa.finish_flag !== 1'b1 && n < 64) begin step_a(1'b0, 1'b0, 32'h0, 32'h0); n++; end
        ntot++;
        if (n !== 1 || ifa.busy !== 1'b0) begin
            nbad++;
            $display("FAIL timeout_latency: edges=%0d busy=%b, want edges=1 busy=0", n, ifa.busy);
        end
        expv = exp_q.pop_front();
        obs  = {ifa.cause, ifa.timeout_flag, ifa.cycle_count, ifa.instret_count};
        ntot++;
        if (obs !== expv) begin
            nbad++;
            $display("FAIL timeout_result: got %h want %h", obs, expv);
        end
    endtask

    task automatic test_ebreak_vs_watchdog();
        step_a(1'b1, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 19; k++) step_a(1'b0, 1'b0, 32'h0, 32'h0);
        step_a(1'b0, 1'b1, 32'h200, INSTR_EBREAK);
        exp_q.push_back({EBREAK, 1'b0, 32'd21, 32'd1});
        ntot++;
        if (ifa.busy !== 1'b1 || ifa.finish_flag !== 1'b0 || ifa.timeout_flag !== 1'b0) begin
            nbad++;
            $display("FAIL prio_drain: busy=%b fin=%b to=%b, want 1 0 0", ifa.busy, ifa.finish_flag, ifa.timeout_flag);
        end
        n = 0;
        while (ifa.finish_flag !== 1'b1 && n < 64) begin step_a(1'b0, 1'b0, 32'h0, 32'h0); n++; end
        ntot++;
        if (n !== 1) begin
            nbad++;
            $display("FAIL prio_latency: edges=%0d want 1", n);
        end
        expv = exp_q.pop_front();
        obs  = {ifa.cause, ifa.timeout_flag, ifa.cycle_count, ifa.instret_count};
        ntot++;
        if (obs !== expv) begin
            nbad++;
            $display("FAIL prio_result: got %h want %h", obs, expv);
        end
    endtask

    task automatic test_reset_mid_drain();
        step_a(1'b1, 1'b0, 32'h0, 32'h0);
        step_a(1'b0, 1'b1, 32'h300, INSTR_ECALL);
        ntot++;
        if (ifa.busy !== 1'b1 || ifa.cause !== ECALL) begin
            nbad++;
            $display("FAIL in_drain: busy=%b cause=%0d, want busy=1 cause=1", ifa.busy, ifa.cause);
        end
        #1 rst_n = 1'b0;
        #1;
        ntot++;
        if ({ifa.busy, ifa.finish_flag, ifa.timeout_flag, ifa.cause, ifa.cycle_count, ifa.instret_count} !== '0) begin
            nbad++;
            $display("FAIL async_reset: busy=%b fin=%b cause=%0d cyc=%0d ret=%0d, want all 0",
                     ifa.busy, ifa.finish_flag, ifa.cause, ifa.cycle_count, ifa.instret_count);
        end
        @(negedge clock);
        rst_n = 1'b1;
        step_a(1'b1, 1'b0, 32'h0, 32'h0);
        step_a(1'b0, 1'b1, 32'h10, ADD);
        ntot++;
        if (ifa.cycle_count !== 32'd1 || ifa.instret_count !== 32'd1 || ifa.busy !== 1'b1) begin
            nbad++;
            $display("FAIL restart_count: cyc=%0d ret=%0d busy=%b, want 1 1 1",
                     ifa.cycle_count, ifa.instret_count, ifa.busy);
        end
        step_a(1'b0, 1'b1, 32'h14, ADD);
        step_a(1'b0, 1'b1, 32'h18, INSTR_EBREAK);
        exp_q.push_back({EBREAK, 1'b0, 32'd4, 32'd3});
        n = 0;
        while (ifa.finish_flag !== 1'b1 && n < 64) begin step_a(1'b0, 1'b0, 32'h0, 32'h0); n++; end
        expv = exp_q.pop_front();
        obs  = {ifa.cause, ifa.timeout_flag, ifa.cycle_count, ifa.instret_count};
        ntot++;
        if (n !== 1 || obs !== expv) begin
            nbad++;
            $display("FAIL clean_run: edges=%0d got %h, want edges=1 %h", n, obs, expv);
        end
    endtask

    task automatic test_saturate();
        step_b(1'b1, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 19; k++) step_b(1'b0, 1'b1, 32'h400 + 32'(4 * k), ADD);
        step_b(1'b0, 1'b1, 32'h500, INSTR_ECALL);
        exp_q.push_back({ECALL, 1'b0, 32'd15, 32'd15});
        n = 0;
        while (ifb.finish_flag !== 1'b1 && n < 64) begin step_b(1'b0, 1'b0, 32'h0, 32'h0); n++; end
        expv = exp_q.pop_front();
        obs  = {ifb.cause, ifb.timeout_flag, 28'd0, ifb.cycle_count, 28'd0, ifb.instret_count};
        ntot++;
        if (n !== 0 || obs !== expv || ifb.busy !== 1'b0) begin
            nbad++;
            $display("FAIL sat_result: edges=%0d got %h busy=%b, want edges=0 %h busy=0", n, obs, ifb.busy, expv);
        end
        step_b(1'b1, 1'b0, 32'h0, 32'h0);
        ntot++;
        if ({ifb.busy, ifb.finish_flag, ifb.cause, ifb.cycle_count, ifb.instret_count} !== {2'b10, 3'd0, 8'd0}) begin
            nbad++;
            $display("FAIL done_restart: busy=%b fin=%b cause=%0d cyc=%0d ret=%0d, want 1 0 0 0 0",
                     ifb.busy, ifb.finish_flag, ifb.cause, ifb.cycle_count, ifb.instret_count);
        end
        step_b(1'b0, 1'b1, 32'h80, JAL);
        step_b(1'b0, 1'b1, 32'h80, JAL);
        step_b(1'b0, 1'b1, 32'h84, JAL);
        step_b(1'b0, 1'b1, 32'h84, JAL);
        ntot++;
        if (ifb.finish_flag !== 1'b0 || ifb.busy !== 1'b1) begin
            nbad++;
            $display("FAIL loop_reload: fin=%b busy=%b, want fin=0 busy=1", ifb.finish_flag, ifb.busy);
        end
        step_b(1'b0, 1'b1, 32'h84, JAL);
        exp_q.push_back({SELFLOOP, 1'b0, 32'd5, 32'd5});
        n = 0;
        while (ifb.finish_flag !== 1'b1 && n < 64) begin step_b(1'b0, 1'b0, 32'h0, 32'h0); n++; end
        expv = exp_q.pop_front();
        obs  = {ifb.cause, ifb.timeout_flag, 28'd0, ifb.cycle_count, 28'd0, ifb.instret_count};
        ntot++;
        if (n !== 0 || obs !== expv) begin
            nbad++;
            $display("FAIL loop3_result: edges=%0d got %h, want edges=0 %h", n, obs, expv);
        end
    endtask

    initial begin
        ifa.start = 1'b0; ifa.instr_valid = 1'b0; ifa.pc = '0; ifa.instr = '0;
        ifb.start = 1'b0; ifb.instr_valid = 1'b0; ifb.pc = '0; ifb.instr = '0;
        test_reset();
        test_ecall();
        test_selfloop();
        test_timeout();
        test_ebreak_vs_watchdog();
        test_reset_mid_drain();
        test_saturate();
        ntot++;
        if (exp_q.size() !== 0) begin
            nbad++;
            $display("FAIL scoreboard_left: %0d entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, want finish before 200000");
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/riscv_run_monitor.md
# riscv_run_monitor

Synthesizable run/halt monitor for the single-cycle RISC-V core. It sits beside the core on the retire stream and decides when a program has finished. It replaces the core's bare finish flag with:
- parametrised halt detection (ECALL, EBREAK, self-loop);
- a cycle watchdog;
- saturating cycle and retired-instruction counters;
- a latched finish cause.

Benches and the top-level wrap stop on `finish_flag` and report `cause`, `cycle_count` and `instret_count`.

## Interface
Parameters:
- `XLEN`, 32, PC and instruction width (instruction compare uses the low 32 bits).
- `CNT_W`, 32, width of `cycle_count` and `instret_count`.
- `TIMEOUT_CYCLES`, 100000, watchdog limit in RUN cycles; 0 disables the watchdog.
- `LOOP_REPEAT`, 2, number of consecutive retires at an unchanged PC that declares a self-loop halt; 0 disables self-loop detection.
- `DRAIN_CYCLES`, 1, cycles spent in DRAIN after a halt instruction before finish is flagged; 0 is legal.

Ports:
- `clock` in 1: the single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: one-cycle pulse that begins a run.
- `instr_valid` in 1: the core retired `instr` at `pc` this cycle.
- `pc` in XLEN: PC of the retiring instruction.
- `instr` in XLEN: the retiring instruction word.
- `busy` out 1: high in RUN or DRAIN.
- `finish_flag` out 1: high in DONE (any cause).
- `timeout_flag` out 1: high in DONE when `cause` is TIMEOUT.
- `cause` out 3: latched finish cause.
- `cycle_count` out CNT_W: cycles elapsed in RUN plus DRAIN.
- `instret_count` out CNT_W: instructions retired in RUN.

## Operation
States: IDLE, RUN, DRAIN, DONE.

Transitions:
- IDLE: on `start` -> RUN. On entering RUN, clear both counters, `cause`, the loop counter and `last_pc_valid`.
- RUN:
  - ECALL (0x00000073) or EBREAK (0x00100073) retired -> DRAIN; if `DRAIN_CYCLES`=0, go straight to DONE.
  - Self-loop detected -> DRAIN, same zero-drain rule.
  - Watchdog: `cycle_count` equal to `TIMEOUT_CYCLES`-1 at an edge -> DONE directly, cause TIMEOUT.
- DRAIN: drain counter runs 0..`DRAIN_CYCLES`-1, then -> DONE. Retires during DRAIN are ignored.
- DONE: hold all outputs. On `start` -> RUN, with the same clears as from IDLE.

Other rules:
- `start` in RUN or DRAIN is ignored.
- Self-loop tracking, per retire in RUN:
  - first retire after start: load `last_pc`, loop count = 0;
  - `pc` == `last_pc`: loop count + 1;
  - otherwise: loop count = 0 and `last_pc` reloaded;
  - halt when loop count + 1 == `LOOP_REPEAT` on a matching retire.
- Priority when several conditions fire at one edge: ECALL > EBREAK > SELFLOOP > TIMEOUT.
- Counters saturate at all-ones and never wrap.
  - `cycle_count` increments every RUN and DRAIN cycle.
  - `instret_count` increments on each `instr_valid` in RUN, including the halting instruction.
- `cause` is written at the edge the halt or timeout is detected. It is stable through DRAIN and DONE.

## Timing
- Reset (`rst_n` low, at any time, including mid-run): state IDLE, all outputs 0, `cause` = NONE. The first `start` accepted is at the first edge after `rst_n` rises.
- `start` sampled at edge S: `busy` is high after S. The cycle after S is RUN cycle 1, so `cycle_count` reads 1 after edge S+1.
- Halt instruction sampled at edge N: `finish_flag` rises after edge N+`DRAIN_CYCLES`. `busy` falls at the same edge.
- Timeout: `finish_flag` and `timeout_flag` rise at the edge where `cycle_count` would reach `TIMEOUT_CYCLES`. `cycle_count` then reads `TIMEOUT_CYCLES`.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `riscv_mon_pkg` holds:
  - state enum `mon_state_t` (IDLE, RUN, DRAIN, DONE);
  - cause enum `mon_cause_t`: NONE=0, ECALL=1, EBREAK=2, SELFLOOP=3, TIMEOUT=4;
  - constants `INSTR_ECALL` and `INSTR_EBREAK`.
- One sub-module, `sat_counter` (parametrised width, clear, enable, saturate), instantiated twice for the two counters.
- The FSM, loop tracker and drain counter stay in the top module.

## Test plan
1. Reset, `start`, retire 5 ADDs then ECALL at pc 0x18, `DRAIN_CYCLES`=1 -> `finish_flag` rises one edge after ECALL; `cause`=1, `instret_count`=6.
2. `LOOP_REPEAT`=2; retire pc 0x40 `jal x0,0` twice in a row -> halt on the 2nd retire, `cause`=3, `timeout_flag`=0.
3. `TIMEOUT_CYCLES`=20, no halt instruction -> `finish_flag`=`timeout_flag`=1, `cause`=4, `cycle_count`=20.
4. EBREAK retired on the same edge the watchdog expires -> `cause`=2, `timeout_flag`=0.
5. Drop `rst_n` low in the middle of DRAIN -> all outputs 0 immediately, asynchronously. The next `start` gives a clean run with counters restarting from 0.
6. `CNT_W`=4, 20-cycle run -> `cycle_count` holds 15 (saturated). `start` in DONE clears it to 0 and re-enters RUN.
